// File: rtl/fpalu_pipe.sv
// Multi-cycle floating-point add/sub/mul with valid/ready handshakes.
// Fixed 3-clock latency: UNPACK -> EXEC -> NORM -> DONE; truncating, no denormals.
module fpalu_pipe #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   A,
  input  logic [EXP_W+MAN_W:0]   B,
  input  logic [1:0]             op,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   Result,
  output logic                   overflow,
  output logic                   underflow,
  output logic                   invalid
);

  localparam int unsigned W    = 1 + EXP_W + MAN_W;
  localparam int unsigned SW   = MAN_W + 1;
  localparam int unsigned PW   = 2 * SW;
  localparam int unsigned XW   = EXP_W + 2;
  localparam int unsigned NW   = EXP_W + 3;
  localparam int unsigned LZW  = $clog2(PW);
  localparam int unsigned EMAX = (1 << EXP_W) - 1;

  localparam logic [XW-1:0] BIAS = XW'((1 << (EXP_W - 1)) - 1);
  localparam logic [W-1:0]  QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W - 1){1'b0}}};

  localparam logic [1:0] OpSub = 2'b01;
  localparam logic [1:0] OpMul = 2'b10;
  localparam logic [1:0] OpRsv = 2'b11;

  typedef enum logic [2:0] {StIdle, StUnpack, StExec, StNorm, StDone} state_e;

  state_e state_q, state_d;

  logic [W-1:0] a_q, b_q;
  logic [1:0]   op_q;

  logic             un_sa_q, un_sb_q, un_inv_q;
  logic [EXP_W-1:0] un_ea_q, un_eb_q;
  logic [SW-1:0]    un_ma_q, un_mb_q;
  logic [1:0]       un_op_q;
  logic             un_sa_d, un_sb_d, un_inv_d;
  logic [EXP_W-1:0] un_ea_d, un_eb_d;
  logic [SW-1:0]    un_ma_d, un_mb_d;

  logic          ex_sign_q, ex_inv_q, ex_sign_d;
  logic [PW-1:0] ex_man_q, ex_man_d;
  logic [XW-1:0] ex_exp_q, ex_exp_d;
  logic [1:0]    ex_op_q;

  logic [W-1:0] res_q, res_d;
  logic         ovf_q, ovf_d, unf_q, unf_d, inv_q, inv_d;

  // Control
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (in_valid) state_d = StUnpack;
      StUnpack: state_d = StExec;
      StExec:   state_d = StNorm;
      StNorm:   state_d = StDone;
      StDone:   if (out_ready) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);

  // Unpack: zero/denormal exponent flushes the significand to exact zero
  always_comb begin
    un_sa_d  = a_q[W-1];
    un_sb_d  = b_q[W-1];
    un_ea_d  = a_q[W-2 -: EXP_W];
    un_eb_d  = b_q[W-2 -: EXP_W];
    un_ma_d  = (un_ea_d == '0) ? '0 : {1'b1, a_q[MAN_W-1:0]};
    un_mb_d  = (un_eb_d == '0) ? '0 : {1'b1, b_q[MAN_W-1:0]};
    un_inv_d = (&un_ea_d) || (&un_eb_d) || (op_q == OpRsv);
  end

  // Exec
  logic             sb_eff, a_big, s_l;
  logic [EXP_W-1:0] e_l, e_s, diff;
  logic [SW-1:0]    m_l, m_s, m_al;
  logic [SW:0]      sum;

  always_comb begin
    sb_eff = un_sb_q ^ (un_op_q == OpSub);
    a_big  = {un_ea_q, un_ma_q} >= {un_eb_q, un_mb_q};
    e_l    = a_big ? un_ea_q : un_eb_q;
    e_s    = a_big ? un_eb_q : un_ea_q;
    m_l    = a_big ? un_ma_q : un_mb_q;
    m_s    = a_big ? un_mb_q : un_ma_q;
    s_l    = a_big ? un_sa_q : sb_eff;
    diff   = e_l - e_s;
    m_al   = (32'(diff) > MAN_W + 1) ? '0 : (m_s >> diff);
    if (un_sa_q == sb_eff) begin
      sum = {1'b0, m_l} + {1'b0, m_al};
    end else begin
      sum = {1'b0, m_l} - {1'b0, m_al};
    end
    // Both paths leave the hidden-1 position at bit PW-2, carry at PW-1
    if (un_op_q == OpMul) begin
      ex_man_d  = PW'(un_ma_q) * PW'(un_mb_q);
      ex_exp_d  = {2'b00, un_ea_q} + {2'b00, un_eb_q} - BIAS;
      ex_sign_d = un_sa_q ^ un_sb_q;
    end else begin
      ex_man_d  = {sum, {MAN_W{1'b0}}};
      ex_exp_d  = {2'b00, e_l};
      ex_sign_d = s_l;
    end
  end

  // Normalise and select the final result
  logic             found;
  logic [LZW-1:0]   lz;
  logic [NW-1:0]    nexp;
  logic [MAN_W-1:0] nfrac;

  always_comb begin
    lz    = '0;
    found = 1'b0;
    for (int i = PW - 2; i >= 0; i--) begin
      if (!found && ex_man_q[i]) begin
        found = 1'b1;
        lz    = LZW'(PW - 2 - i);
      end
    end
    nexp = {ex_exp_q[XW-1], ex_exp_q};
    if (ex_man_q[PW-1]) begin
      nfrac = MAN_W'(ex_man_q >> (MAN_W + 1));
      nexp  = nexp + NW'(1);
    end else begin
      nfrac = MAN_W'((ex_man_q << lz) >> MAN_W);
      nexp  = nexp - NW'(lz);
    end

    res_d = res_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
    inv_d = inv_q;
    if (state_q == StNorm) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
      inv_d = 1'b0;
      if (ex_inv_q) begin
        inv_d = 1'b1;
        res_d = (ex_op_q == OpRsv) ? '0 : QNAN;
      end else if (ex_man_q == '0) begin
        res_d = {(ex_op_q == OpMul) ? ex_sign_q : 1'b0, {(W - 1){1'b0}}};
      end else if (!nexp[NW-1] && (nexp >= NW'(EMAX))) begin
        res_d = {ex_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        ovf_d = 1'b1;
      end else if (nexp[NW-1] || (nexp == '0)) begin
        res_d = {ex_sign_q, {(W - 1){1'b0}}};
        unf_d = 1'b1;
      end else begin
        res_d = {ex_sign_q, nexp[EXP_W-1:0], nfrac};
      end
    end
  end

  // Datapath stages carry no reset; only the visible result registers do
  always_ff @(posedge clock) begin
    if (state_q == StIdle && in_valid) begin
      a_q  <= A;
      b_q  <= B;
      op_q <= op;
    end
    if (state_q == StUnpack) begin
      un_sa_q  <= un_sa_d;
      un_sb_q  <= un_sb_d;
      un_ea_q  <= un_ea_d;
      un_eb_q  <= un_eb_d;
      un_ma_q  <= un_ma_d;
      un_mb_q  <= un_mb_d;
      un_inv_q <= un_inv_d;
      un_op_q  <= op_q;
    end
    if (state_q == StExec) begin
      ex_man_q  <= ex_man_d;
      ex_exp_q  <= ex_exp_d;
      ex_sign_q <= ex_sign_d;
      ex_inv_q  <= un_inv_q;
      ex_op_q   <= un_op_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      res_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
      inv_q <= 1'b0;
    end else begin
      res_q <= res_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
      inv_q <= inv_d;
    end
  end

  assign Result    = res_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;
  assign invalid   = inv_q;

endmodule

// File: tb/tb_fpalu_pipe.sv
// Scoreboard bench for fpalu_pipe: single precision plus a half-precision instance.
module tb_fpalu_pipe;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] A, B, Result;
  logic [1:0]  op;
  logic        overflow, underflow, invalid;

  logic        h_in_valid, h_in_ready, h_out_valid, h_out_ready;
  logic [15:0] h_A, h_B, h_Result;
  logic [1:0]  h_op;
  logic        h_overflow, h_underflow, h_invalid;

  int n_checks = 0;
  int n_fail   = 0;
  logic [34:0] sb_q[$];

  always #5 clock = ~clock;

  fpalu_pipe u_dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .Result(Result), .overflow(overflow), .underflow(underflow), .invalid(invalid)
  );

  fpalu_pipe #(.EXP_W(5), .MAN_W(10)) u_dut_h (
    .clock(clock), .reset(reset), .in_valid(h_in_valid), .in_ready(h_in_ready),
    .A(h_A), .B(h_B), .op(h_op), .out_valid(h_out_valid), .out_ready(h_out_ready),
    .Result(h_Result), .overflow(h_overflow), .underflow(h_underflow), .invalid(h_invalid)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [1:0] o,
                       input logic [34:0] expv);
    check_eq("in_ready_idle", 64'(in_ready), 64'd1);
    A        = a;
    B        = b;
    op       = o;
    in_valid = 1'b1;
    sb_q.push_back(expv);
    step();
    in_valid = 1'b0;
    check_eq("in_ready_busy", 64'(in_ready), 64'd0);
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
  endtask

  task automatic collect(input string tag);
    logic [34:0] e;
    check_eq({tag, "_outstanding"}, 64'(sb_q.size()), 64'd1);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      if (out_valid) begin
        check_eq({tag, "_res"}, 64'(Result), 64'(e[34:3]));
        check_eq({tag, "_flags"}, 64'({overflow, underflow, invalid}), 64'(e[2:0]));
      end
    end
  endtask

  // Flags ordered {overflow, underflow, invalid}
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [1:0] o, input logic [31:0] r, input logic [2:0] f);
    int lat;
    issue(a, b, o, {r, f});
    wait_out(lat);
    check_eq({tag, "_latency"}, 64'(lat), 64'd3);
    collect(tag);
    step();
    check_eq({tag, "_ready_after"}, 64'({in_ready, out_valid}), 64'b10);
  endtask

  initial begin
    int lat;
    int seen;
    logic [34:0] e;

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; A = '0; B = '0; op = '0;
    h_in_valid = 1'b0; h_out_ready = 1'b1; h_A = '0; h_B = '0; h_op = '0;
    step();
    step();
    reset = 1'b0;
    check_eq("reset_ctl", 64'({in_ready, out_valid}), 64'b10);
    check_eq("reset_res", 64'(Result), 64'd0);
    check_eq("reset_flags", 64'({overflow, underflow, invalid}), 64'd0);

    run_op("add",    32'h3F800000, 32'h40000000, 2'b00, 32'h40400000, 3'b000);
    run_op("mul",    32'h3FC00000, 32'h40000000, 2'b10, 32'h40400000, 3'b000);
    run_op("cancel", 32'h3F800000, 32'h3F800000, 2'b01, 32'h00000000, 3'b000);
    run_op("ovf",    32'h7F000000, 32'h40000000, 2'b10, 32'h7F800000, 3'b100);
    run_op("unf",    32'h00800000, 32'h3F000000, 2'b10, 32'h00000000, 3'b010);
    run_op("inf",    32'h7F800000, 32'h3F800000, 2'b00, 32'h7FC00000, 3'b001);
    run_op("rsv",    32'h40400000, 32'h3F800000, 2'b11, 32'h00000000, 3'b001);
    run_op("addneg", 32'h3F800000, 32'hBF000000, 2'b00, 32'h3F000000, 3'b000);
    run_op("subneg", 32'h3F800000, 32'h40000000, 2'b01, 32'hBF800000, 3'b000);
    run_op("mulzero", 32'h00000000, 32'hC0000000, 2'b10, 32'h80000000, 3'b000);
    run_op("mulneg", 32'hC0000000, 32'h40400000, 2'b10, 32'hC0C00000, 3'b000);

    // Back-pressure plus an in_valid pulse during EXEC
    out_ready = 1'b0;
    issue(32'h3F800000, 32'h40000000, 2'b00, {32'h40400000, 3'b000});
    step();
    A = 32'h7F800000; B = 32'h7F800000; op = 2'b10; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    wait_out(lat);
    check_eq("hold_latency", 64'(lat), 64'd1);
    e = (sb_q.size() != 0) ? sb_q[0] : '0;
    for (int i = 0; i < 10; i++) begin
      step();
      check_eq("hold_ctl", 64'({out_valid, in_ready}), 64'b10);
      check_eq("hold_res", 64'({Result, overflow, underflow, invalid}), 64'(e));
    end
    collect("hold");
    out_ready = 1'b1;
    step();
    check_eq("release_ready", 64'({in_ready, out_valid}), 64'b10);

    // Reset during NORM discards the in-flight result
    issue(32'h3F800000, 32'h40000000, 2'b00, {32'h40400000, 3'b000});
    void'(sb_q.pop_back());
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_eq("rst_norm_ctl", 64'({in_ready, out_valid}), 64'b10);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (out_valid) seen++;
    end
    check_eq("rst_norm_no_out", 64'(seen), 64'd0);
    run_op("after_rst", 32'h3FC00000, 32'h40000000, 2'b10, 32'h40400000, 3'b000);

    // Reset wins over a simultaneous request
    A = 32'h3F800000; B = 32'h3F800000; op = 2'b00; in_valid = 1'b1; reset = 1'b1;
    step();
    reset = 1'b0; in_valid = 1'b0;
    check_eq("rst_vs_valid", 64'({in_ready, out_valid}), 64'b10);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (out_valid) seen++;
    end
    check_eq("rst_vs_valid_no_out", 64'(seen), 64'd0);

    // Half-precision instance
    for (int k = 0; k < 2; k++) begin
      check_eq("h_ready", 64'(h_in_ready), 64'd1);
      h_A = 16'h3C00; h_B = 16'h4000; h_op = (k == 0) ? 2'b00 : 2'b10; h_in_valid = 1'b1;
      step();
      h_in_valid = 1'b0;
      lat = 0;
      while (!h_out_valid && lat < 20) begin
        step();
        lat++;
      end
      check_eq("h_latency", 64'(lat), 64'd3);
      check_eq("h_res", 64'(h_Result), (k == 0) ? 64'h4200 : 64'h4000);
      check_eq("h_flags", 64'({h_overflow, h_underflow, h_invalid}), 64'd0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fpalu_pipe.md
# fpalu_pipe

Parametrised, multi-cycle floating-point ALU. It performs add, subtract and multiply on packed IEEE-754-style operands with configurable exponent and mantissa widths. Operands are accepted through a valid/ready handshake and results are returned through one. Each result carries overflow, underflow and invalid flags. It is the successor to the fixed-width, fixed-single-precision ALU in the datapath and sits between the operand register file and the writeback stage.

## Interface
- EXP_W, 8: exponent field width; bias = 2^(EXP_W-1)-1.
- MAN_W, 23: stored mantissa (fraction) width; W = 1+EXP_W+MAN_W.
- clock  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high reset; one clock, one synchronous active-high reset.
- in_valid  in  1  operand request.
- in_ready  out  1  high only in IDLE.
- A  in  W  operand A {sign, exp, frac}.
- B  in  W  operand B.
- op  in  2  00 add, 01 sub (A-B), 10 mul, 11 reserved.
- out_valid  out  1  Result and flags valid.
- out_ready  in  1  consumer accepts result.
- Result  out  W  packed result.
- overflow  out  1  exponent overflow, result saturated to ±inf.
- underflow  out  1  exponent underflow, result flushed to ±0.
- invalid  out  1  inf/NaN operand or reserved op.

## Operation
- FSM states and transitions:
  - IDLE → UNPACK on in_valid&&in_ready. A, B and op are captured on that edge.
  - UNPACK → EXEC unconditionally.
  - EXEC → NORM unconditionally.
  - NORM → DONE unconditionally.
  - DONE → IDLE on out_ready, else stay in DONE.
- UNPACK:
  - Split fields and restore the hidden 1.
  - exp==0 (zero/denormal) operand is treated as exact zero.
  - exp==all-ones operand, or op==11, sets the invalid path. This path bypasses the arithmetic.
- EXEC, add/sub:
  - Sub inverts B's sign.
  - Align the smaller-exponent significand right by the exponent difference. A difference > MAN_W+1 contributes 0.
  - Magnitude add or subtract on (MAN_W+2)-bit significands. The result sign is the larger-magnitude operand's sign.
- EXEC, mul:
  - sign = sA^sB; exp = eA+eB-bias (EXP_W+2-bit signed).
  - Significand product is 2(MAN_W+1) bits.
- NORM:
  - Single-cycle leading-zero count with left shift, or a 1-bit right shift on carry-out or product MSB. Adjust the exponent accordingly.
  - Truncate to MAN_W fraction bits; no rounding.
- Result rules, in priority order:
  - invalid: Result = 0 if op==11, else canonical qNaN {0, all-ones, 1, 0...}; invalid=1.
  - Zero magnitude (zero operand to mul, or exact add cancellation): Result = +0 for add/sub; sign sA^sB for mul.
  - Final biased exp ≥ 2^EXP_W-1: Result = {sign, all-ones, 0}; overflow=1.
  - Final biased exp ≤ 0: Result = {sign, 0, 0}; underflow=1.
  - Otherwise the packed normal result with all flags 0.
- Result and the flags are registered. They hold stable throughout DONE and change only on entering DONE.
- Reset values: state=IDLE, in_ready=1, out_valid=0, Result=0, all flags=0.

## Timing
- Acceptance edge N. UNPACK in cycle N..N+1, EXEC in N+1..N+2, NORM in N+2..N+3.
- out_valid rises on edge N+3, a fixed latency of 3 clocks.
- Transfer completes on a clock with out_valid&&out_ready. The FSM is in IDLE (in_ready=1) the following cycle.
- Minimum initiation interval is 4 clocks. in_ready is low from edge N until the DONE→IDLE edge.
- in_valid during a busy state is ignored. The requester must hold its operands until in_ready.
- out_ready held low keeps DONE indefinitely, with Result and flags unchanged.
- reset asserted in any state returns to IDLE on that edge. out_valid is 0 the next cycle, any in-flight result is discarded, and no stale result is emitted.
- in_valid and reset high on the same edge: reset wins and no capture occurs.

## Test plan
- Add, default params: A=3F800000, B=40000000, op=00 → out_valid on edge N+3, Result=40400000, flags 0.
- Mul and cancellation: 3FC00000×40000000, op=10 → 40400000. Then 3F800000−3F800000, op=01 → 00000000, flags 0.
- Overflow/underflow: 7F000000×40000000 → 7F800000 with overflow=1. 00800000×3F000000 → 00000000 with underflow=1.
- Invalid: 7F800000+3F800000 → 7FC00000 with invalid=1. op=11 with any operands → 00000000 with invalid=1.
- Handshake:
  - Hold out_ready=0 for 10 cycles after out_valid: Result and out_valid remain stable and in_ready stays 0.
  - in_valid pulsed during EXEC: the pulse is ignored.
  - Release out_ready: next cycle in_ready=1.
- Reset and params:
  - reset during NORM → IDLE with out_valid=0, no result emitted; the next operation is correct.
  - Rerun with EXP_W=5, MAN_W=10: 3C00+4000 → 4200.
